// File: rtl/tcu_priv_irq_queue.sv
// Privileged-side interrupt queue of the TCU.
// Buffers timer and core-request events in a small FIFO of {cause, act_id}
// records and presents the head record to the core as a level interrupt
// until it is acknowledged. The timer has fixed priority over core requests.
// Optional feature: define TCU_PRIV_IRQ_TIMER_COALESCE_EN to keep at most one
// timer record queued (further timer events are accepted and dropped).
module tcu_priv_irq_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned ACT_ID_SIZE = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           timer_int_valid_i,
  output logic                           timer_int_stall_o,
  input  logic                           corereq_valid_i,
  input  logic [ACT_ID_SIZE-1:0]         corereq_act_i,
  output logic                           corereq_stall_o,
  output logic                           irq_o,
  output logic                           irq_cause_o,
  output logic [ACT_ID_SIZE-1:0]         irq_act_o,
  input  logic                           irq_ack_i,
  output logic [$clog2(QUEUE_DEPTH):0]   irq_count_o
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(QUEUE_DEPTH);

  logic                   cause_q [QUEUE_DEPTH];
  logic [ACT_ID_SIZE-1:0] act_q   [QUEUE_DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, empty;
  logic timer_push, core_push, push, pop;
  logic push_cause;
  logic [ACT_ID_SIZE-1:0] push_act;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

`ifdef TCU_PRIV_IRQ_TIMER_COALESCE_EN
  logic timer_pending_q, timer_pending_d;

  // A queued timer record absorbs further timer events, so the timer never waits on it.
  assign timer_int_stall_o = reset_i | (full & ~timer_pending_q);
  assign corereq_stall_o   = reset_i | full | (timer_int_valid_i & ~timer_pending_q);
  assign timer_push        = timer_int_valid_i & ~timer_int_stall_o & ~timer_pending_q;

  // Set on a timer push, cleared when the (single) timer record leaves the head.
  always_comb begin
    timer_pending_d = timer_pending_q;
    if (timer_push) begin
      timer_pending_d = 1'b1;
    end else if (pop && !cause_q[rd_ptr_q]) begin
      timer_pending_d = 1'b0;
    end
  end

  // Timer-pending flag register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timer_pending_q <= 1'b0;
    end else begin
      timer_pending_q <= timer_pending_d;
    end
  end
`else
  // Stalls come from registered fullness only; an ack never un-stalls in the same cycle.
  assign timer_int_stall_o = reset_i | full;
  assign corereq_stall_o   = reset_i | full | timer_int_valid_i;
  assign timer_push        = timer_int_valid_i & ~timer_int_stall_o;
`endif

  assign core_push  = corereq_valid_i & ~corereq_stall_o;
  assign push       = timer_push | core_push;
  assign pop        = irq_ack_i & ~empty;
  assign push_cause = ~timer_push;
  assign push_act   = timer_push ? '0 : corereq_act_i;

  // Pointer and occupancy next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers; reset flushes the queue.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      cause_q[wr_ptr_q] <= push_cause;
      act_q[wr_ptr_q]   <= push_act;
    end
  end

  assign irq_o       = ~empty;
  assign irq_cause_o = empty ? 1'b0 : cause_q[rd_ptr_q];
  assign irq_act_o   = empty ? '0 : act_q[rd_ptr_q];
  assign irq_count_o = count_q;

endmodule

// File: tb/tb_tcu_priv_irq_queue.sv
// Scoreboard bench for tcu_priv_irq_queue: accepted events are pushed into an
// expected-record queue, and the DUT head, count and stalls are compared
// against it every cycle; acks pop the expected queue.
module tb_tcu_priv_irq_queue;

  localparam int unsigned Depth = 4;
  localparam int unsigned ActW  = 16;

  typedef struct packed {
    logic            cause;
    logic [ActW-1:0] act;
  } ent_t;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            timer_int_valid_i;
  logic            timer_int_stall_o;
  logic            corereq_valid_i;
  logic [ActW-1:0] corereq_act_i;
  logic            corereq_stall_o;
  logic            irq_o;
  logic            irq_cause_o;
  logic [ActW-1:0] irq_act_o;
  logic            irq_ack_i;
  logic [2:0]      irq_count_o;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  logic pend_m = 1'b0;

  tcu_priv_irq_queue #(
    .QUEUE_DEPTH(Depth),
    .ACT_ID_SIZE(ActW)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .timer_int_valid_i(timer_int_valid_i),
    .timer_int_stall_o(timer_int_stall_o),
    .corereq_valid_i  (corereq_valid_i),
    .corereq_act_i    (corereq_act_i),
    .corereq_stall_o  (corereq_stall_o),
    .irq_o            (irq_o),
    .irq_cause_o      (irq_cause_o),
    .irq_act_o        (irq_act_o),
    .irq_ack_i        (irq_ack_i),
    .irq_count_o      (irq_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check against the model, update the model at posedge.
  task automatic step(input logic tv, input logic cv, input logic [ActW-1:0] act,
                      input logic ack, input logic rst, output logic c_acc);
    logic exp_ts, exp_cs, full_m, t_acc, t_push;
    ent_t head, popped;
    timer_int_valid_i = tv;
    corereq_valid_i   = cv;
    corereq_act_i     = act;
    irq_ack_i         = ack;
    reset_i           = rst;
    #1;
    full_m = (sb.size() == Depth);
`ifdef TCU_PRIV_IRQ_TIMER_COALESCE_EN
    exp_ts = rst | (full_m & ~pend_m);
    exp_cs = rst | full_m | (tv & ~pend_m);
`else
    exp_ts = rst | full_m;
    exp_cs = rst | full_m | tv;
`endif
    head = (sb.size() != 0) ? sb[0] : '0;
    check_val("timer_stall", 32'(timer_int_stall_o), 32'(exp_ts));
    check_val("core_stall", 32'(corereq_stall_o), 32'(exp_cs));
    check_val("irq", 32'(irq_o), 32'(sb.size() != 0));
    check_val("count", 32'(irq_count_o), 32'(sb.size()));
    check_val("cause", 32'(irq_cause_o), 32'(head.cause));
    check_val("act", 32'(irq_act_o), 32'(head.act));
    t_acc  = tv & ~exp_ts;
    c_acc  = cv & ~exp_cs;
`ifdef TCU_PRIV_IRQ_TIMER_COALESCE_EN
    t_push = t_acc & ~pend_m;
`else
    t_push = t_acc;
`endif
    @(posedge clk_i);
    if (rst) begin
      sb.delete();
      pend_m = 1'b0;
    end else begin
      if (ack && sb.size() != 0) begin
        popped = sb.pop_front();
        if (!popped.cause) pend_m = 1'b0;
      end
      if (t_push) begin
        sb.push_back('{cause: 1'b0, act: '0});
        pend_m = 1'b1;
      end
      if (c_acc) sb.push_back('{cause: 1'b1, act: act});
    end
    @(negedge clk_i);
  endtask

  initial begin
    logic acc;
    int   exp_coal;
    int   n;
    timer_int_valid_i = 1'b0;
    corereq_valid_i   = 1'b0;
    corereq_act_i     = '0;
    irq_ack_i         = 1'b0;
    reset_i           = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);

    // Reset values: stalls high while in reset, outputs zero.
    step(0, 0, 0, 0, 1, acc);
    step(1, 1, 16'h0007, 0, 0, acc);    // first cycle out of reset: timer pushed
    step(0, 0, 0, 1, 0, acc);           // timer at head, ack
    step(0, 0, 0, 0, 0, acc);

    // Priority: timer wins, core request pushed the next cycle.
    step(1, 1, 16'h1234, 0, 0, acc);
    check_val("prio_core_stalled", 32'(acc), 32'd0);
    step(0, 1, 16'h1234, 0, 0, acc);
    check_val("prio_core_taken", 32'(acc), 32'd1);
    step(0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 0, 0, acc);

    // Fill, hold a fifth request, ack once, then drain across the wrap.
    for (int i = 1; i <= 4; i++) step(0, 1, 16'(i), 0, 0, acc);
    step(0, 1, 16'd5, 0, 0, acc);
    check_val("full_held", 32'(acc), 32'd0);
    step(0, 1, 16'd5, 1, 0, acc);       // stalls still high in the ack cycle
    check_val("full_ack_held", 32'(acc), 32'd0);
    step(0, 1, 16'd5, 0, 0, acc);
    check_val("after_ack_taken", 32'(acc), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 0, 0, acc);

    // Ack edge cases: ack while empty, push to empty with ack, push+ack at count 2.
    step(0, 0, 0, 1, 0, acc);
    step(0, 1, 16'hAAAA, 1, 0, acc);
    step(0, 1, 16'hBBBB, 0, 0, acc);
    step(0, 1, 16'hCCCC, 1, 0, acc);
    step(0, 0, 0, 0, 0, acc);

    // Reset mid-operation at count 3.
    step(0, 1, 16'hDDDD, 0, 0, acc);
    step(0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, acc);

    // Three timer events without ack.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, acc);
`ifdef TCU_PRIV_IRQ_TIMER_COALESCE_EN
    exp_coal = 1;
`else
    exp_coal = 3;
`endif
    check_val("coalesce_count", 32'(irq_count_o), 32'(exp_coal));
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step(0, 0, 0, 1, 0, acc);
      n++;
    end
    step(0, 0, 0, 0, 0, acc);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0), 16'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0), acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcu_priv_irq_queue.md
# tcu_priv_irq_queue

Privileged-side interrupt queue of the TCU, directly downstream of the privileged timer. It accepts the timer interrupt and core-request events through valid/stall handshakes. Accepted events are buffered in a small FIFO of interrupt records. The head record is presented to the core as a level interrupt until the core acknowledges it. Backpressure (stall) goes to the sources whenever the FIFO cannot take an entry.

## Interface
- QUEUE_DEPTH, 4, number of FIFO entries; power of two, >= 2
- ACT_ID_SIZE, 16, width of the activity ID carried by a core request
- clk_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  reset; synchronous, active-high
- timer_int_valid_i  in  1  timer interrupt pending; held until accepted
- timer_int_stall_o  out  1  timer event not accepted this cycle
- corereq_valid_i  in  1  core-request event; held with data until accepted
- corereq_act_i  in  ACT_ID_SIZE  activity ID of the core request
- corereq_stall_o  out  1  core request not accepted this cycle
- irq_o  out  1  interrupt to core; high while the FIFO is non-empty
- irq_cause_o  out  1  head cause: 0 = timer, 1 = core request
- irq_act_o  out  ACT_ID_SIZE  head activity ID; 0 for timer entries
- irq_ack_i  in  1  one-cycle pulse; core consumed the head entry
- irq_count_o  out  $clog2(QUEUE_DEPTH)+1  number of queued entries

## Operation
- **FIFO state**: circular buffer of {cause, act_id} with registered read/write pointers and count. full = (count == QUEUE_DEPTH); empty = (count == 0).
- **Accept rules**:
  - Timer accepted when timer_int_valid_i && !timer_int_stall_o.
  - Core request accepted when corereq_valid_i && !corereq_stall_o.
  - At most one push per cycle.
- **Stall rules**:
  - timer_int_stall_o = full.
  - corereq_stall_o = full || timer_int_valid_i, so the timer has fixed priority.
  - Stalls are derived from registered full only. A same-cycle ack never un-stalls a source.
- **Push data**:
  - Timer pushes {0, 0}.
  - Core request pushes {1, corereq_act_i}.
- **Pop**: irq_ack_i while non-empty pops the head. irq_ack_i while empty is ignored.
- **Simultaneous push and pop** while non-empty and not full: count unchanged, both pointers advance.
- **Head outputs**: irq_cause_o and irq_act_o are driven from the head entry when non-empty. When empty they are forced to 0.
- **Pointer wrap-around**: pointers wrap modulo QUEUE_DEPTH. The count distinguishes full from empty.

## Timing
- **Reset values**:
  - irq_o = 0, irq_cause_o = 0, irq_act_o = 0, irq_count_o = 0.
  - Both stall outputs are 1 while reset_i is high; no accept occurs.
  - The first cycle after reset both stalls are 0 (empty FIFO). corereq_stall_o still follows timer_int_valid_i.
- **Push latency**: an entry pushed in cycle N is visible on irq_o, irq_cause_o, irq_act_o and irq_count_o in cycle N+1.
- **Pop latency**: an ack in cycle N removes the head. The next entry, or irq_o = 0, appears in cycle N+1.
- **Push to empty FIFO with ack in the same cycle**: the ack is ignored and the pushed entry is presented in N+1.
- **Full FIFO with ack in cycle N**: stalls remain high in cycle N and drop in N+1.
- **Reset mid-operation**: the FIFO is flushed, all queued events are lost, and outputs return to reset values on the next edge.
- Stall outputs are combinational from registered state and timer_int_valid_i only; no path from irq_ack_i.

## Configuration
- **TCU_PRIV_IRQ_TIMER_COALESCE_EN defined**:
  - A registered timer_pending flag marks that a timer entry is queued.
  - While timer_pending = 1, timer_int_stall_o = 0 even if full. The timer event is accepted and dropped, with no push.
  - timer_pending is cleared when the timer entry is popped. It is set on a timer push.
  - corereq_stall_o ignores timer_int_valid_i while timer_pending = 1.
- **Undefined**: every timer event is queued as its own entry, subject to the normal full stall. No timer_pending flag exists.

## Test plan
- **Basic timer path**: reset, then timer_int_valid_i = 1 for one cycle -> accepted, irq_o = 1 next cycle, irq_cause_o = 0, irq_count_o = 1. irq_ack_i pulse -> irq_o = 0 and count 0 one cycle later.
- **Priority**: timer and corereq (act 0x1234) valid in the same cycle -> timer pushed first and corereq stalled one cycle. Head order is timer, then {1, 0x1234}. Two acks drain both.
- **Full and wrap**:
  - Push 4 core requests (act 1..4) -> irq_count_o = 4 and both stalls high.
  - A 5th request (act 5) stays held; ack once -> stall drops the cycle after the ack, act 5 is pushed.
  - Drain order is 2, 3, 4, 5, across pointer wrap.
- **Ack edge cases**: ack while empty -> no change. Push and ack together at count 2 -> count stays 2 and the head advances.
- **Reset mid-operation**: reset_i at count 3 -> next cycle count 0, irq_o = 0, stalls 0.
- **Coalescing**:
  - With TCU_PRIV_IRQ_TIMER_COALESCE_EN, 3 timer events with no ack -> count 1 and no stall seen by the timer.
  - Without the macro -> count 3.
